imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_byte_assembler.sv | 55 +++++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader.
//   state_e          : loader FSM states (IDLE, LOAD, WRITE, DONE)
//   BYTES_PER_WORD   : bytes assembled into one instruction word
//   BYTE_CNT_WIDTH   : width of the byte counter inside the assembler
//   INDEX_WIDTH      : word index / word count width (256 must fit)
//   word_to_byte_offset : converts a word index into a byte offset
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_WIDTH = 2;
  localparam int WORD_WIDTH     = BYTES_PER_WORD * 8;
  localparam int INDEX_WIDTH    = 9;

  localparam logic [BYTE_CNT_WIDTH-1:0] LAST_BYTE = BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1);

  function automatic logic [INDEX_WIDTH+1:0] word_to_byte_offset(
    input logic [INDEX_WIDTH-1:0] idx
  );
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_assembler
// Collects a big-endian byte stream into 32-bit words. Each accepted byte is
// shifted in at the bottom, so after four shifts the first byte sits in
// [31:24].
// Ports:
//   clk, reset    : system clock, async active-high reset
//   clear_i       : drop any partial word and restart the byte counter
//   shift_en_i    : accept byte_i this cycle
//   byte_i        : incoming byte
//   last_byte_o   : the next accepted byte completes a word
//   word_o        : shift register contents
//   word_full_o   : word_o currently holds four freshly assembled bytes
// ---------------------------------------------------------------------------
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  shift_en_i,
  input  logic [7:0]            byte_i,
  output logic                  last_byte_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_full_o
);

  logic [WORD_WIDTH-1:0]     shreg_q;
  logic [BYTE_CNT_WIDTH-1:0] cnt_q;
  logic                      full_q;

  // The counter wraps from 3 back to 0 on its own, so consecutive words need
  // no explicit clear; full_q marks the cycle(s) after a completed word until
  // the next byte starts overwriting it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else if (shift_en_i) begin
      shreg_q <= {shreg_q[WORD_WIDTH-9:0], byte_i};
      cnt_q   <= cnt_q + 1'b1;
      full_q  <= (cnt_q == LAST_BYTE);
    end
  end

  assign last_byte_o = (cnt_q == LAST_BYTE);
  assign word_o      = shreg_q;
  assign word_full_o = full_q;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads a stream of instruction bytes into an external instruction store.
// A session is started with a one-cycle start pulse; bytes are assembled
// big-endian into words which are written at base + 4*index.
// Ports:
//   clk, reset         : system clock, async active-high reset
//   start              : begin a session (ignored while busy)
//   base_addr          : byte address of first word (low 2 bits dropped)
//   word_count         : number of words in the session (0..511)
//   byte_valid/data    : byte source, accepted when byte_ready is high
//   byte_ready         : loader takes a byte this cycle
//   wr_en/addr/data    : write port to the instruction store
//   busy               : session in progress
//   done               : one-cycle pulse on successful completion
//   error              : sticky overflow flag, cleared by the next start
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CACHE_DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [INDEX_WIDTH-1:0] word_count,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(CACHE_DEPTH);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [INDEX_WIDTH-1:0] count_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   error_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;

  logic                   startAccept;
  logic                   byteAccept;
  logic                   lastByte;
  logic                   wordFull;
  logic [WORD_WIDTH-1:0]  asmWord;
  logic [INDEX_WIDTH-1:0] indexNext;
  logic [ADDR_WIDTH:0]    wordNum;
  logic                   overflow;
  logic [ADDR_WIDTH-1:0]  addrNow;

  assign startAccept = (state_q == IDLE) && start;
  assign byteAccept  = byte_ready && byte_valid;
  assign indexNext   = index_q + 1'b1;
  assign addrNow     = base_q + ADDR_WIDTH'(word_to_byte_offset(index_q));

  // Word position in the store, computed one bit wider than the address so a
  // base near the top of the address space cannot wrap below the limit.
  assign wordNum  = (ADDR_WIDTH+1)'(base_q[ADDR_WIDTH-1:2]) + (ADDR_WIDTH+1)'(index_q);
  assign overflow = (wordNum >= DEPTH_LIMIT);

  imem_loader_byte_assembler byte_assembler (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (startAccept),
    .shift_en_i  (byteAccept),
    .byte_i      (byte_data),
    .last_byte_o (lastByte),
    .word_o      (asmWord),
    .word_full_o (wordFull)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (word_count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (byteAccept && lastByte) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (overflow) begin
          state_d = IDLE;
        end else if (indexNext == count_q) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        busy  = 1'b1;
        wr_en = wordFull && !overflow;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
    endcase
  end

  // Session registers: base is word-aligned at capture, the index only
  // advances on a successful write so an overflow leaves it pointing at the
  // word that was refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      error_q <= 1'b0;
    end else if (startAccept) begin
      base_q  <= base_addr & ~ADDR_WIDTH'(3);
      count_q <= word_count;
      index_q <= '0;
      error_q <= 1'b0;
    end else if (state_q == WRITE) begin
      if (overflow) begin
        error_q <= 1'b1;
      end else begin
        index_q <= indexNext;
      end
    end
  end

  // The write port shows the live word while wr_en is high and the last
  // written values afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (wr_en) begin
      wr_addr_q <= addrNow;
      wr_data_q <= DATA_WIDTH'(asmWord);
    end
  end

  assign wr_addr = wr_en ? addrNow : wr_addr_q;
  assign wr_data = wr_en ? DATA_WIDTH'(asmWord) : wr_data_q;
  assign error   = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader. Inputs change right after the
// falling edge; outputs are observed on the falling edge.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [8:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  int tests  = 0;
  int failed = 0;
  int doneCount;
  int busyCycles;
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  imem_loader #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .CACHE_DEPTH (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Records every write, done pulse and busy cycle seen on the falling edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wrAddrQ.push_back(wr_addr);
      wrDataQ.push_back(wr_data);
    end
    if (done === 1'b1) doneCount++;
    if (busy === 1'b1) busyCycles++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic resetMonitor();
    wrAddrQ.delete();
    wrDataQ.delete();
    doneCount  = 0;
    busyCycles = 0;
  endtask

  task automatic startSession(input logic [31:0] b, input logic [8:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Holds byte_valid until the loader takes the byte, then returns on the
  // falling edge after the accepting rising edge.
  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      tests++;
      failed++;
      $display("[TB] FAIL send_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    while (busy === 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    resetMonitor();
    @(negedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    tests++; if (byte_ready !== 1'b0) begin failed++; $display("[TB] FAIL reset_byte_ready: got %b required 0", byte_ready); end
    tests++; if (wr_en !== 1'b0) begin failed++; $display("[TB] FAIL reset_wr_en: got %b required 0", wr_en); end
    tests++; if (done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    tests++; if (error !== 1'b0) begin failed++; $display("[TB] FAIL reset_error: got %b required 0", error); end
    tests++; if (wr_addr !== 32'h0) begin failed++; $display("[TB] FAIL reset_wr_addr: got %h required 0", wr_addr); end
    tests++; if (wr_data !== 32'h0) begin failed++; $display("[TB] FAIL reset_wr_data: got %h required 0", wr_data); end
  endtask

  task automatic test_basic();
    logic [7:0]  bytes[8]   = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h10, 8'h00};
    logic [31:0] expAddr[2] = '{32'h0000_0000, 32'h0000_0004};
    logic [31:0] expData[2] = '{32'h2008_0005, 32'h3C01_1000};
    resetMonitor();
    // Reset drops and start is raised together: the first edge with reset
    // low must take the start.
    reset = 1'b0;
    startSession(32'h0, 9'd2);
    tests++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL basic_busy_after_start: got %b required 1", busy); end
    for (int i = 0; i < 8; i++) begin
      sendByte(bytes[i]);
      if (i % 4 == 3) begin
        tests++; if (wr_en !== 1'b1) begin failed++; $display("[TB] FAIL basic_wr_latency%0d: wr_en=%b required 1", i / 4, wr_en); end
        tests++; if (wr_addr !== expAddr[i/4]) begin failed++; $display("[TB] FAIL basic_live_addr%0d: got %h required %h", i / 4, wr_addr, expAddr[i/4]); end
        tests++; if (wr_data !== expData[i/4]) begin failed++; $display("[TB] FAIL basic_live_data%0d: got %h required %h", i / 4, wr_data, expData[i/4]); end
      end
    end
    waitIdle("basic");
    tests++; if (wrAddrQ.size() != 2) begin failed++; $display("[TB] FAIL basic_write_count: got %0d required 2", wrAddrQ.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wrAddrQ.size()) begin
        tests++; if (wrAddrQ[i] !== expAddr[i] || wrDataQ[i] !== expData[i]) begin
          failed++; $display("[TB] FAIL basic_write%0d: got (%h,%h) required (%h,%h)", i, wrAddrQ[i], wrDataQ[i], expAddr[i], expData[i]);
        end
      end
    end
    tests++; if (doneCount != 1) begin failed++; $display("[TB] FAIL basic_done_pulses: got %0d required 1", doneCount); end
    tests++; if (wr_addr !== 32'h4 || wr_data !== 32'h3C01_1000) begin
      failed++; $display("[TB] FAIL basic_hold: got (%h,%h) required (00000004,3c011000)", wr_addr, wr_data);
    end
  endtask

  task automatic test_misaligned();
    logic [7:0] bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    resetMonitor();
    startSession(32'h13, 9'd1);
    foreach (bytes[i]) sendByte(bytes[i]);
    waitIdle("misaligned");
    tests++; if (wrAddrQ.size() != 1) begin failed++; $display("[TB] FAIL misaligned_write_count: got %0d required 1", wrAddrQ.size()); end
    if (wrAddrQ.size() > 0) begin
      tests++; if (wrAddrQ[0] !== 32'h10) begin failed++; $display("[TB] FAIL misaligned_addr: got %h required 00000010", wrAddrQ[0]); end
      tests++; if (wrDataQ[0] !== 32'hDEAD_BEEF) begin failed++; $display("[TB] FAIL misaligned_data: got %h required deadbeef", wrDataQ[0]); end
    end
    tests++; if (doneCount != 1) begin failed++; $display("[TB] FAIL misaligned_done: got %0d required 1", doneCount); end
  endtask

  task automatic test_toggle_valid();
    logic [7:0]  bytes[8]   = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h10, 8'h00};
    logic [31:0] expAddr[2] = '{32'h0000_0100, 32'h0000_0104};
    logic [31:0] expData[2] = '{32'h2008_0005, 32'h3C01_1000};
    int  idx   = 0;
    int  guard = 0;
    bit  ph    = 1'b1;
    bit  acc;
    resetMonitor();
    startSession(32'h100, 9'd2);
    while (idx < 8 && guard < 100) begin
      byte_valid = ph;
      byte_data  = bytes[idx];
      acc        = ph && (byte_ready === 1'b1);
      @(negedge clk);
      if (acc) idx++;
      ph = !ph;
      guard++;
    end
    byte_valid = 1'b0;
    tests++; if (idx != 8) begin failed++; $display("[TB] FAIL toggle_bytes_sent: got %0d required 8", idx); end
    waitIdle("toggle");
    tests++; if (wrAddrQ.size() != 2) begin failed++; $display("[TB] FAIL toggle_write_count: got %0d required 2", wrAddrQ.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wrAddrQ.size()) begin
        tests++; if (wrAddrQ[i] !== expAddr[i] || wrDataQ[i] !== expData[i]) begin
          failed++; $display("[TB] FAIL toggle_write%0d: got (%h,%h) required (%h,%h)", i, wrAddrQ[i], wrDataQ[i], expAddr[i], expData[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  bytes[12]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic [31:0] expAddr[2] = '{32'h0000_03F8, 32'h0000_03FC};
    logic [31:0] expData[2] = '{32'h1122_3344, 32'h5566_7788};
    resetMonitor();
    startSession(32'h3F8, 9'd4);
    foreach (bytes[i]) sendByte(bytes[i]);
    tests++; if (wr_en !== 1'b0) begin failed++; $display("[TB] FAIL overflow_wr_suppressed: wr_en=%b required 0", wr_en); end
    waitIdle("overflow");
    tests++; if (error !== 1'b1) begin failed++; $display("[TB] FAIL overflow_error: got %b required 1", error); end
    tests++; if (wrAddrQ.size() != 2) begin failed++; $display("[TB] FAIL overflow_write_count: got %0d required 2", wrAddrQ.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < wrAddrQ.size()) begin
        tests++; if (wrAddrQ[i] !== expAddr[i] || wrDataQ[i] !== expData[i]) begin
          failed++; $display("[TB] FAIL overflow_write%0d: got (%h,%h) required (%h,%h)", i, wrAddrQ[i], wrDataQ[i], expAddr[i], expData[i]);
        end
      end
    end
    tests++; if (doneCount != 0) begin failed++; $display("[TB] FAIL overflow_no_done: got %0d required 0", doneCount); end
    // Bytes offered while idle are refused and the flag stays set.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    tests++; if (byte_ready !== 1'b0) begin failed++; $display("[TB] FAIL overflow_idle_ready: got %b required 0", byte_ready); end
    tests++; if (error !== 1'b1) begin failed++; $display("[TB] FAIL overflow_error_sticky: got %b required 1", error); end
    byte_valid = 1'b0;
  endtask

  task automatic test_zero_count();
    resetMonitor();
    startSession(32'h80, 9'd0);
    tests++; if (busy !== 1'b1 || done !== 1'b1) begin failed++; $display("[TB] FAIL zero_done_state: busy=%b done=%b required 1 1", busy, done); end
    tests++; if (error !== 1'b0) begin failed++; $display("[TB] FAIL zero_error_cleared: got %b required 0", error); end
    @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("[TB] FAIL zero_back_idle: busy=%b done=%b required 0 0", busy, done); end
    tests++; if (busyCycles != 1) begin failed++; $display("[TB] FAIL zero_busy_cycles: got %0d required 1", busyCycles); end
    tests++; if (doneCount != 1) begin failed++; $display("[TB] FAIL zero_done_pulses: got %0d required 1", doneCount); end
    tests++; if (wrAddrQ.size() != 0) begin failed++; $display("[TB] FAIL zero_no_write: got %0d required 0", wrAddrQ.size()); end
  endtask

  task automatic test_reset_mid_session();
    logic [7:0] bytes[4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    // Put a nonzero value on the write port first so its clearing is visible.
    resetMonitor();
    startSession(32'h200, 9'd1);
    foreach (bytes[i]) sendByte(bytes[i]);
    waitIdle("mid_prep");
    resetMonitor();
    startSession(32'h40, 9'd1);
    sendByte(8'hAA);
    sendByte(8'hBB);
    #2;
    reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin failed++; $display("[TB] FAIL mid_async_ctrl: busy=%b byte_ready=%b required 0 0", busy, byte_ready); end
    tests++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin failed++; $display("[TB] FAIL mid_async_port: got (%h,%h) required (0,0)", wr_addr, wr_data); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    startSession(32'h40, 9'd1);
    foreach (bytes[i]) sendByte(bytes[i]);
    waitIdle("mid");
    tests++; if (wrAddrQ.size() != 1) begin failed++; $display("[TB] FAIL mid_write_count: got %0d required 1", wrAddrQ.size()); end
    if (wrAddrQ.size() > 0) begin
      tests++; if (wrAddrQ[0] !== 32'h40 || wrDataQ[0] !== 32'hCAFE_F00D) begin
        failed++; $display("[TB] FAIL mid_write: got (%h,%h) required (00000040,cafef00d)", wrAddrQ[0], wrDataQ[0]);
      end
    end
    tests++; if (doneCount != 1) begin failed++; $display("[TB] FAIL mid_done: got %0d required 1", doneCount); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_toggle_valid();
    test_overflow();
    test_zero_count();
    test_reset_mid_session();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
